// File: rtl/data_memory_mc_pkg.sv
// Shared encodings, FSM states and lane-mask helper for the multi-cycle data memory.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic        err;
    } req_t;

    // Little-endian lane enables; reserved size enables nothing.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: byte_enable = 4'b0001 << lane;
            SZ_HALF: byte_enable = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: byte_enable = 4'b1111;
            default: byte_enable = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_mc_if.sv
// Request/response bundle of the data memory, plus the store-trace side channel.
interface data_memory_mc_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        busy;
    // Store trace fields, valid for the response cycle of a committed store.
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, req_pc,
        input  req_ready, resp_valid, resp_rdata, resp_error, busy,
        input  trace_valid, trace_pc, trace_addr, trace_data
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, req_pc,
        output req_ready, resp_valid, resp_rdata, resp_error, busy,
        output trace_valid, trace_pc, trace_addr, trace_data
    );

endinterface

// File: rtl/data_memory_mc_lane_align.sv
// Combinational byte-lane store merge and load extract/extend.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [3:0]  mask,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  lane,
    output logic [31:0] merged,
    output logic [31:0] load_data
);

    logic [31:0] rep;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        // Replicate the right-aligned store data so every lane sees its own copy.
        case (size)
            SZ_BYTE: rep = {4{wdata[7:0]}};
            SZ_HALF: rep = {2{wdata[15:0]}};
            default: rep = wdata;
        endcase
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) merged[8*k +: 8] = rep[8*k +: 8];
        end
    end

    always_comb begin
        b = old_word[{lane, 3'b000} +: 8];
        h = lane[1] ? old_word[31:16] : old_word[15:0];
        case (size)
            SZ_BYTE: load_data = {{24{sgn & b[7]}}, b};
            SZ_HALF: load_data = {{16{sgn & h[15]}}, h};
            default: load_data = old_word;
        endcase
    end

endmodule

// File: rtl/data_memory_mc.sv
// Multi-cycle byte/half/word data memory with configurable latency and error detection.
module data_memory_mc
    import mem_pkg::*;
#(
    parameter int ADDR_BITS    = 11,
    parameter int LATENCY      = 2,
    parameter int ENABLE_TRACE = 1
) (
    input  logic             clock,
    input  logic             reset,
    data_memory_mc_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_BITS;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    req_t        req_q;
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;
    logic        error_q;
    logic        trace_valid_q;
    logic [31:0] trace_pc_q, trace_addr_q, trace_data_q;

    logic        accept, commit, err_in;
    logic [3:0]  mask;
    logic [31:0] old_word, merged, load_data;
    logic [ADDR_BITS-1:0] idx;

    assign bus.req_ready  = !reset && (state != ST_WAIT);
    assign accept         = bus.req_valid && bus.req_ready;
    assign commit         = (state == ST_WAIT) && (cnt == 4'd1);
    assign bus.resp_valid = (state == ST_RESP);
    assign bus.busy       = (state == ST_WAIT);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_error = error_q;
    assign bus.trace_valid = trace_valid_q;
    assign bus.trace_pc    = trace_pc_q;
    assign bus.trace_addr  = trace_addr_q;
    assign bus.trace_data  = trace_data_q;

    // Error classification happens on the raw inputs so it is latched with the request.
    always_comb begin
        err_in = 1'b0;
        case (bus.req_size)
            SZ_BYTE: err_in = 1'b0;
            SZ_HALF: err_in = bus.req_addr[0];
            SZ_WORD: err_in = |bus.req_addr[1:0];
            default: err_in = 1'b1;
        endcase
        if (|(bus.req_addr >> (ADDR_BITS + 2))) err_in = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: if (accept) begin
                state_nxt = ST_WAIT;
                cnt_nxt   = 4'(LATENCY);
            end
            ST_WAIT: if (cnt == 4'd1) begin
                state_nxt = ST_RESP;
                cnt_nxt   = 4'd0;
            end else begin
                cnt_nxt   = cnt - 4'd1;
            end
            ST_RESP: if (accept) begin
                state_nxt = ST_WAIT;
                cnt_nxt   = 4'(LATENCY);
            end else begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign idx      = req_q.addr[ADDR_BITS+1:2];
    assign old_word = mem[idx];
    assign mask     = byte_enable(req_q.size, req_q.addr[1:0]);

    mem_lane_align u_align (
        .old_word  (old_word),
        .wdata     (req_q.wdata),
        .mask      (mask),
        .size      (req_q.size),
        .sgn       (req_q.sgn),
        .lane      (req_q.addr[1:0]),
        .merged    (merged),
        .load_data (load_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= 4'd0;
            rdata_q       <= 32'd0;
            error_q       <= 1'b0;
            trace_valid_q <= 1'b0;
            trace_pc_q    <= 32'd0;
            trace_addr_q  <= 32'd0;
            trace_data_q  <= 32'd0;
            req_q         <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            trace_valid_q <= 1'b0;
            if (accept) begin
                req_q <= '{write: bus.req_write, size: bus.req_size, sgn: bus.req_signed,
                           addr: bus.req_addr, wdata: bus.req_wdata, pc: bus.req_pc,
                           err: err_in};
            end
            if (commit) begin
                error_q       <= req_q.err;
                rdata_q       <= (req_q.err || req_q.write) ? 32'd0 : load_data;
                trace_valid_q <= (ENABLE_TRACE != 0) && req_q.write && !req_q.err;
                trace_pc_q    <= req_q.pc;
                trace_addr_q  <= {req_q.addr[31:2], 2'b00};
                trace_data_q  <= merged;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
        end else if (commit && req_q.write && !req_q.err) begin
            mem[idx] <= merged;
        end
    end

endmodule

// File: tb/tb_data_memory_mc.sv
// Directed bench: vector table on a LATENCY=2 instance plus reset, back-to-back and latency sequences.
module tb_data_memory_mc;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   ntests = 0;
    int   nfail  = 0;
    int   ntrace = 0;

    always #5 clock = ~clock;

    data_memory_mc_if m2 ();
    data_memory_mc_if m1 ();
    data_memory_mc_if m4 ();

    data_memory_mc #(.ADDR_BITS(11), .LATENCY(2), .ENABLE_TRACE(1)) u2 (.clock(clock), .reset(reset), .bus(m2));
    data_memory_mc #(.ADDR_BITS(11), .LATENCY(1), .ENABLE_TRACE(0)) u1 (.clock(clock), .reset(reset), .bus(m1));
    data_memory_mc #(.ADDR_BITS(11), .LATENCY(4), .ENABLE_TRACE(0)) u4 (.clock(clock), .reset(reset), .bus(m4));

    always @(negedge clock) begin
        if (m2.trace_valid) begin
            $display("@%h: *%h <= %h", m2.trace_pc, m2.trace_addr, m2.trace_data);
            ntrace++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic        tr;
        logic [31:0] tword;
    } vec_t;

    // One request on the LATENCY=2 instance; reports the response and the trace channel.
    task automatic xact(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic tv, output logic [31:0] tp, output logic [31:0] ta,
                        output logic [31:0] td);
        int n;
        @(negedge clock);
        m2.req_valid = 1'b1; m2.req_write = w; m2.req_size = sz; m2.req_signed = sg;
        m2.req_addr = a; m2.req_wdata = d; m2.req_pc = pc;
        n = 0;
        while (!m2.req_ready && n < 50) begin @(negedge clock); n++; end
        @(posedge clock); #1;
        m2.req_valid = 1'b0;
        lat = 0; rd = 'x; er = 1'bx; tv = 1'bx; tp = 'x; ta = 'x; td = 'x;
        while (lat < 40) begin
            @(posedge clock); #1;
            lat++;
            if (m2.resp_valid) begin
                rd = m2.resp_rdata; er = m2.resp_error; tv = m2.trace_valid;
                tp = m2.trace_pc; ta = m2.trace_addr; td = m2.trace_data;
                break;
            end
        end
        if (lat >= 40) begin
            nfail++; ntests++;
            $display("FAIL xact_timeout: got no resp_valid expected resp within 40 edges");
        end
    endtask

    // Three word requests on the LATENCY=1 instance with req_valid held high throughout.
    task automatic b2b(input logic w, input logic [31:0] base);
        int k, nresp;
        int acc[3];
        logic [31:0] rd[3];
        logic rdy;
        @(negedge clock);
        k = 0; nresp = 0;
        m1.req_valid = 1'b1; m1.req_write = w; m1.req_size = 2'd2; m1.req_signed = 1'b0;
        m1.req_addr = base; m1.req_wdata = 32'h1111_0000; m1.req_pc = 32'h0;
        for (int cyc = 0; cyc < 30 && nresp < 3; cyc++) begin
            rdy = m1.req_ready;
            @(posedge clock); #1;
            if (m1.resp_valid) begin
                rd[nresp] = m1.resp_rdata;
                nresp++;
            end
            if (rdy && m1.req_valid) begin
                acc[k] = cyc;
                k++;
                if (k < 3) begin
                    m1.req_addr  = base + 32'(4 * k);
                    m1.req_wdata = 32'h1111_0000 + 32'(k);
                end else begin
                    m1.req_valid = 1'b0;
                end
            end
            @(negedge clock);
        end
        m1.req_valid = 1'b0;
        chk("b2b_resp_count", 32'(nresp), 32'd3);
        chk("b2b_accepts", 32'(k), 32'd3);
        if (nresp == 3 && k == 3) begin
            chk("b2b_gap0", 32'(acc[1] - acc[0]), 32'd2);
            chk("b2b_gap1", 32'(acc[2] - acc[1]), 32'd2);
            for (int i = 0; i < 3; i++)
                chk("b2b_rdata", rd[i], w ? 32'd0 : 32'h1111_0000 + 32'(i));
        end
    endtask

    vec_t v[20];

    initial begin
        logic [31:0] rd, tp, ta, td;
        logic        er, tv;
        int          lat, t0, saw;

        v[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,   32'h12345678, 32'h0,        1'b0, 1'b1, 32'h12345678};
        v[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'h12345678, 1'b0, 1'b0, 32'h0};
        v[2]  = '{1'b1, 2'd0, 1'b0, 32'h11,   32'hFFFFFFAB, 32'h0,        1'b0, 1'b1, 32'h1234AB78};
        v[3]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'h1234AB78, 1'b0, 1'b0, 32'h0};
        v[4]  = '{1'b0, 2'd0, 1'b1, 32'h11,   32'h0,        32'hFFFFFFAB, 1'b0, 1'b0, 32'h0};
        v[5]  = '{1'b0, 2'd0, 1'b0, 32'h11,   32'h0,        32'h000000AB, 1'b0, 1'b0, 32'h0};
        v[6]  = '{1'b0, 2'd1, 1'b1, 32'h12,   32'h0,        32'h00001234, 1'b0, 1'b0, 32'h0};
        v[7]  = '{1'b1, 2'd2, 1'b0, 32'h4,    32'h00000055, 32'h0,        1'b0, 1'b1, 32'h00000055};
        v[8]  = '{1'b1, 2'd2, 1'b0, 32'h6,    32'hCAFEF00D, 32'h0,        1'b1, 1'b0, 32'h0};
        v[9]  = '{1'b0, 2'd1, 1'b1, 32'h3,    32'h0,        32'h0,        1'b1, 1'b0, 32'h0};
        v[10] = '{1'b0, 2'd2, 1'b0, 32'h4,    32'h0,        32'h00000055, 1'b0, 1'b0, 32'h0};
        v[11] = '{1'b1, 2'd2, 1'b0, 32'h2000, 32'hA5A5A5A5, 32'h0,        1'b1, 1'b0, 32'h0};
        v[12] = '{1'b0, 2'd3, 1'b0, 32'h10,   32'h0,        32'h0,        1'b1, 1'b0, 32'h0};
        v[13] = '{1'b1, 2'd1, 1'b0, 32'h12,   32'h77778001, 32'h0,        1'b0, 1'b1, 32'h8001AB78};
        v[14] = '{1'b0, 2'd1, 1'b1, 32'h12,   32'h0,        32'hFFFF8001, 1'b0, 1'b0, 32'h0};
        v[15] = '{1'b0, 2'd0, 1'b0, 32'h13,   32'h0,        32'h00000080, 1'b0, 1'b0, 32'h0};
        v[16] = '{1'b0, 2'd1, 1'b0, 32'h10,   32'h0,        32'h0000AB78, 1'b0, 1'b0, 32'h0};
        v[17] = '{1'b0, 2'd1, 1'b1, 32'h10,   32'h0,        32'hFFFFAB78, 1'b0, 1'b0, 32'h0};
        v[18] = '{1'b1, 2'd2, 1'b0, 32'h1FFC, 32'h0BADF00D, 32'h0,        1'b0, 1'b1, 32'h0BADF00D};
        v[19] = '{1'b0, 2'd2, 1'b0, 32'h1FFC, 32'h0,        32'h0BADF00D, 1'b0, 1'b0, 32'h0};

        m2.req_valid = 0; m2.req_write = 0; m2.req_size = 0; m2.req_signed = 0;
        m2.req_addr = 0; m2.req_wdata = 0; m2.req_pc = 0;
        m1.req_valid = 0; m1.req_write = 0; m1.req_size = 0; m1.req_signed = 0;
        m1.req_addr = 0; m1.req_wdata = 0; m1.req_pc = 0;
        m4.req_valid = 0; m4.req_write = 0; m4.req_size = 0; m4.req_signed = 0;
        m4.req_addr = 0; m4.req_wdata = 0; m4.req_pc = 0;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("ready_in_reset", {31'd0, m2.req_ready}, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("ready_after_reset", {31'd0, m2.req_ready}, 32'd1);
        chk("resp_valid_reset", {31'd0, m2.resp_valid}, 32'd0);
        chk("busy_reset", {31'd0, m2.busy}, 32'd0);
        chk("rdata_reset", m2.resp_rdata, 32'd0);
        chk("error_reset", {31'd0, m2.resp_error}, 32'd0);

        // Vector table on LATENCY=2
        for (int i = 0; i < 20; i++) begin
            xact(v[i].w, v[i].sz, v[i].sg, v[i].addr, v[i].wdata, 32'h400 + 32'(4 * i),
                 rd, er, lat, tv, tp, ta, td);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
            chk($sformatf("v%0d_rdata", i), rd, v[i].rdata);
            chk($sformatf("v%0d_error", i), {31'd0, er}, {31'd0, v[i].err});
            chk($sformatf("v%0d_trace", i), {31'd0, tv}, {31'd0, v[i].tr});
            if (v[i].tr) begin
                chk($sformatf("v%0d_trace_data", i), td, v[i].tword);
                chk($sformatf("v%0d_trace_addr", i), ta, {v[i].addr[31:2], 2'b00});
                chk($sformatf("v%0d_trace_pc", i), tp, 32'h400 + 32'(4 * i));
            end
        end

        // Reset one cycle after accepting a store; a request offered during reset is dropped.
        t0 = ntrace;
        @(negedge clock);
        chk("rst_store_ready", {31'd0, m2.req_ready}, 32'd1);
        m2.req_valid = 1'b1; m2.req_write = 1'b1; m2.req_size = 2'd2;
        m2.req_addr = 32'h20; m2.req_wdata = 32'hDEADBEEF; m2.req_pc = 32'h900;
        @(posedge clock); #1;
        m2.req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        m2.req_valid = 1'b1; m2.req_write = 1'b0; m2.req_addr = 32'h10;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        m2.req_valid = 1'b0;
        saw = 0;
        repeat (6) begin
            @(posedge clock); #1;
            if (m2.resp_valid) saw++;
        end
        chk("rst_no_resp", 32'(saw), 32'd0);
        chk("rst_no_trace", 32'(ntrace - t0), 32'd0);
        xact(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h904, rd, er, lat, tv, tp, ta, td);
        chk("rst_load_20", rd, 32'd0);
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h908, rd, er, lat, tv, tp, ta, td);
        chk("rst_cleared_10", rd, 32'd0);

        // Back-to-back on LATENCY=1
        b2b(1'b1, 32'h40);
        b2b(1'b0, 32'h40);

        // LATENCY=4 occupancy
        @(negedge clock);
        m4.req_valid = 1'b1; m4.req_write = 1'b0; m4.req_size = 2'd2; m4.req_addr = 32'h0;
        @(posedge clock); #1;
        m4.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lat4_busy%0d", i), {31'd0, m4.busy}, 32'd1);
            chk($sformatf("lat4_ready%0d", i), {31'd0, m4.req_ready}, 32'd0);
            chk($sformatf("lat4_noresp%0d", i), {31'd0, m4.resp_valid}, 32'd0);
            @(posedge clock); #1;
        end
        chk("lat4_resp", {31'd0, m4.resp_valid}, 32'd1);
        chk("lat4_ready_resp", {31'd0, m4.req_ready}, 32'd1);
        chk("lat4_busy_resp", {31'd0, m4.busy}, 32'd0);
        @(posedge clock); #1;
        chk("lat4_resp_pulse", {31'd0, m4.resp_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/data_memory_mc.md
Name: data_memory_mc

Overview:
Parametrised successor to the single-cycle word-only data memory.
- Adds byte, halfword and word access with sign or zero load extension.
- Adds a configurable access latency behind a valid/ready request and one-cycle response handshake, so the pipeline MEM stage can be tested against slow memory.
- Detects misaligned and out-of-range accesses.
- Keeps the existing store-trace line format for golden-log comparison.

Parameters:
ADDR_BITS, 11, word-address bits; depth = 2^ADDR_BITS 32-bit words.
LATENCY, 2, edges from request accept to commit/response; legal range 1..15.
ENABLE_TRACE, 1, when 1 every committed store prints the trace line.

Ports:
clock  in  1  system clock, all state updates on the rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_write  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
req_signed  in  1  sign-extend load (ignored for word and for stores)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
req_pc  in  32  PC of the issuing instruction, trace only
resp_valid  out  1  one-cycle pulse: access complete
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_error  out  1  with resp_valid: misaligned, out of range, or reserved size
busy  out  1  request accepted and not yet responded

Behaviour:
- Interface: reset is synchronous, active-high; clock is the rising-edge clock `clock`.
- FSM states:
  - IDLE: req_ready=1. On accept go to WAIT and load cnt=LATENCY.
  - WAIT: cnt decrements each edge. On the edge where cnt==1, commit the access and go to RESP.
  - RESP: resp_valid=1, req_ready=1. Accept goes to WAIT; otherwise go to IDLE.
- Accept = req_valid && req_ready. On accept, latch write, size, signed, addr, wdata and pc. Request inputs are ignored at all other times.
- Timing: accept on edge E0 gives commit on edge E0+LATENCY; resp_valid is high for the cycle after that edge. Back-to-back throughput is one request per LATENCY+1 cycles.
- busy=1 in WAIT, and in RESP only if a new request was accepted on that RESP cycle's edge.
- Error check is decided at accept from the latched fields. An error is raised for any of:
  - size 3;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:ADDR_BITS+2] != 0.
  An error gives the same latency, no memory update, resp_rdata=0, resp_error=1, and no trace line.
- Byte layout is little-endian. Byte k of a word is bits [8k+7:8k], selected by addr[1:0]; a half uses lane addr[1].
- Store: read-modify-write of the word at addr[ADDR_BITS+1:2]. Only the enabled lanes change, taking the low byte or half of wdata.
- Trace line: `@%h: *%h <= %h` with pc, word-aligned address and merged 32-bit word. It is printed at commit when ENABLE_TRACE=1.
- Load: extract the lane; sign-extend if req_signed, else zero-extend. Word loads pass through unchanged. resp_rdata is registered at commit and holds until the next commit. resp_error=0 on success.
- Reset:
  - clears every memory word to 0;
  - sets state=IDLE, cnt=0, resp_valid=0, resp_rdata=0, resp_error=0, busy=0;
  - req_ready=0 during the reset cycle and 1 from the first cycle after it.
- Reset mid-operation discards the pending request: no write, no response, no trace line. Reset dominates req_valid on the same edge.
- A store is visible to a load accepted in the store's RESP cycle, because the commit precedes the read.

Decomposition:
- Package mem_pkg:
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2;
  - FSM enum ST_IDLE/ST_WAIT/ST_RESP;
  - function byte_enable(size, addr[1:0]) returning a 4-bit lane mask.
- Sub-module mem_lane_align, combinational and separately testable:
  - produces the store merge from old word, wdata and mask;
  - produces load extraction and extension from word, size, signed and addr[1:0].

Test Plan:
- LATENCY=2, store word 0x12345678 @0x10 then load word @0x10 -> resp_valid 2 edges after each accept; rdata=0x12345678; trace "@<pc>: *00000010 <= 12345678".
- Store byte 0xAB @0x11 over 0x12345678 -> word becomes 0x1234AB78. lb @0x11 -> 0xFFFFFFAB; lbu -> 0x000000AB. lh @0x12 -> 0x00001234.
- Store word @0x6, then lh @0x3 -> both resp_error=1, memory @0x4 unchanged, no trace; store @0x2000 with ADDR_BITS=11 -> resp_error=1.
- Back-to-back: hold req_valid high for 3 loads with LATENCY=1 -> accepts every 2 cycles, 3 resp_valid pulses, rdata in order.
- Reset one cycle after accepting a store of 0xDEADBEEF @0x20 -> no resp_valid, no trace, later load @0x20 returns 0.
- LATENCY=4 sweep: assert req_ready=0 and busy=1 for exactly 4 cycles after accept, then resp_valid for exactly 1 cycle.
